// File: rtl/cim_xbar_responder.sv
// Binary-weight compute-in-memory crossbar: input buffer, 1-bit weight array and output buffer.
// A multiply sweeps one column per cycle, writing the saturated, shifted column sum into obuf.
module cim_xbar_responder #(
  parameter int xbar_size     = 512,
  parameter int datatype_size = 4,
  parameter int adc_shift     = 0
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             i_cim_we,
  input  logic [((xbar_size > 1) ? $clog2(xbar_size) : 1)-1:0] i_cim_wr_addr,
  input  logic [datatype_size-1:0]                         i_cim_data,
  input  logic                                             i_cim_start,
  output logic                                             o_cim_busy,
  output logic                                             o_done,
  input  logic                                             i_w_we,
  input  logic [((xbar_size > 1) ? $clog2(xbar_size) : 1)-1:0] i_w_row,
  input  logic [((xbar_size > 1) ? $clog2(xbar_size) : 1)-1:0] i_w_col,
  input  logic                                             i_w_data,
  input  logic [((xbar_size > 1) ? $clog2(xbar_size) : 1)-1:0] i_cim_rd_addr,
  output logic [datatype_size-1:0]                         o_data
);
  localparam int AW    = (xbar_size > 1) ? $clog2(xbar_size) : 1;
  localparam int DW    = datatype_size;
  localparam int ACC_W = DW + AW;
  localparam logic [AW:0]       SIZE_V   = (AW+1)'(xbar_size);
  localparam logic [AW-1:0]     LAST_COL = AW'(xbar_size - 1);
  localparam logic [ACC_W-1:0]  SAT_MAX  = {{AW{1'b0}}, {DW{1'b1}}};

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [AW-1:0]        col_q, col_d;
  logic [DW-1:0]        o_data_q, o_data_d;
  logic [DW-1:0]        ibuf_q [xbar_size];
  logic [DW-1:0]        obuf_q [xbar_size];
  logic [xbar_size-1:0] w_q    [xbar_size];

  logic              in_idle, in_compute;
  logic              ibuf_wr_en, w_wr_en;
  logic [ACC_W-1:0]  acc, shifted;
  logic [DW-1:0]     col_result;

  assign in_idle    = (state_q == S_IDLE);
  assign in_compute = (state_q == S_COMPUTE);
  assign ibuf_wr_en = in_idle && i_cim_we && ({1'b0, i_cim_wr_addr} < SIZE_V);
  assign w_wr_en    = in_idle && i_w_we && ({1'b0, i_w_row} < SIZE_V) && ({1'b0, i_w_col} < SIZE_V);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (i_cim_start) begin
          state_d = S_COMPUTE;
          col_d   = '0;
        end
      end
      S_COMPUTE: begin
        if (col_q == LAST_COL) state_d = S_DONE;
        else                   col_d   = col_q + AW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Column dot product: weights are binary, so each row either adds its input or nothing.
  always_comb begin
    acc = '0;
    for (int r = 0; r < xbar_size; r++) begin
      if (w_q[r][col_q]) acc = acc + ACC_W'(ibuf_q[r]);
    end
    shifted    = acc >> adc_shift;
    col_result = (shifted > SAT_MAX) ? {DW{1'b1}} : shifted[DW-1:0];
  end

  always_comb begin
    o_data_d = '0;
    if ({1'b0, i_cim_rd_addr} < SIZE_V) o_data_d = obuf_q[i_cim_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      o_data_q <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      o_data_q <= o_data_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < xbar_size; gi++) begin : g_row
      logic [DW-1:0] ibuf_d, obuf_d;

      always_comb begin
        ibuf_d = ibuf_q[gi];
        if (ibuf_wr_en && (i_cim_wr_addr == AW'(gi))) ibuf_d = i_cim_data;
        obuf_d = obuf_q[gi];
        if (in_compute && (col_q == AW'(gi))) obuf_d = col_result;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ibuf_q[gi] <= '0;
          obuf_q[gi] <= '0;
        end else begin
          ibuf_q[gi] <= ibuf_d;
          obuf_q[gi] <= obuf_d;
        end
      end

      // Weights have no reset so a programmed crossbar survives rst; rst still blocks writes.
      always_ff @(posedge clk) begin
        if (!rst && w_wr_en && (i_w_row == AW'(gi))) w_q[gi][i_w_col] <= i_w_data;
      end
    end
  endgenerate

  assign o_cim_busy = !in_idle;
  assign o_done     = (state_q == S_DONE);
  assign o_data     = o_data_q;

endmodule

// File: tb/tb_cim_xbar_responder.sv
// Bench for cim_xbar_responder (8x8, 4-bit data); a second instance runs with adc_shift=4.
module tb_cim_xbar_responder;
  localparam int N  = 8;
  localparam int DW = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cim_we;
  logic [AW-1:0] i_cim_wr_addr;
  logic [DW-1:0] i_cim_data;
  logic          i_cim_start;
  logic          i_w_we;
  logic [AW-1:0] i_w_row, i_w_col;
  logic          i_w_data;
  logic [AW-1:0] i_cim_rd_addr;
  logic          busy0, done0, busy4, done4;
  logic [DW-1:0] data0, data4;

  cim_xbar_responder #(.xbar_size(N), .datatype_size(DW), .adc_shift(0)) dut (
    .clk(clk), .rst(rst), .i_cim_we(i_cim_we), .i_cim_wr_addr(i_cim_wr_addr),
    .i_cim_data(i_cim_data), .i_cim_start(i_cim_start), .o_cim_busy(busy0), .o_done(done0),
    .i_w_we(i_w_we), .i_w_row(i_w_row), .i_w_col(i_w_col), .i_w_data(i_w_data),
    .i_cim_rd_addr(i_cim_rd_addr), .o_data(data0));

  cim_xbar_responder #(.xbar_size(N), .datatype_size(DW), .adc_shift(4)) dut_s4 (
    .clk(clk), .rst(rst), .i_cim_we(i_cim_we), .i_cim_wr_addr(i_cim_wr_addr),
    .i_cim_data(i_cim_data), .i_cim_start(i_cim_start), .o_cim_busy(busy4), .o_done(done4),
    .i_w_we(i_w_we), .i_w_row(i_w_row), .i_w_col(i_w_col), .i_w_data(i_w_data),
    .i_cim_rd_addr(i_cim_rd_addr), .o_data(data4));

  always #5 clk = ~clk;

  typedef struct {
    int grp;
    int addr;
    int exp0;
    int exp4;
  } rd_vec_t;

  typedef struct {
    int grp;
    int addr;
    int e0;
    int e4;
  } sb_t;

  rd_vec_t vecs[$];
  sb_t     sb[$];
  int      n_pass  = 0;
  int      n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input int g, input int a, input int e0, input int e4);
    rd_vec_t v;
    v.grp = g; v.addr = a; v.exp0 = e0; v.exp4 = e4;
    vecs.push_back(v);
  endtask

  task automatic wr_w(input int r, input int c, input bit v);
    i_w_we = 1'b1; i_w_row = AW'(r); i_w_col = AW'(c); i_w_data = v;
    step();
    i_w_we = 1'b0;
  endtask

  task automatic wr_ibuf(input int a, input int d);
    i_cim_we = 1'b1; i_cim_wr_addr = AW'(a); i_cim_data = DW'(d);
    step();
    i_cim_we = 1'b0;
  endtask

  task automatic fill_ibuf(input int d);
    for (int a = 0; a < N; a++) wr_ibuf(a, d);
  endtask

  // Drive each read address of a group; the expected pair is queued when the address is
  // driven and popped once the registered read data appears.
  task automatic apply_group(input int g);
    sb_t e, s;
    foreach (vecs[i]) begin
      if (vecs[i].grp == g) begin
        i_cim_rd_addr = AW'(vecs[i].addr);
        s.grp = g; s.addr = vecs[i].addr; s.e0 = vecs[i].exp0; s.e4 = vecs[i].exp4;
        sb.push_back(s);
        step();
        e = sb.pop_front();
        check($sformatf("g%0d_rd%0d_shift0", e.grp, e.addr), int'(data0), e.e0);
        check($sformatf("g%0d_rd%0d_shift4", e.grp, e.addr), int'(data4), e.e4);
      end
    end
  endtask

  task automatic run_and_wait(input string nm);
    int seen;
    seen = 0;
    i_cim_start = 1'b1;
    step();
    i_cim_start = 1'b0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      if (done0) begin
        seen = 1;
        check({nm, "_done_s4"}, int'(done4), 1);
      end
      step();
    end
    check({nm, "_done_seen"}, seen, 1);
  endtask

  initial begin
    int busy_cnt, done_cnt;

    // group 0 / 4: all zero after reset
    for (int a = 0; a < N; a++) add_vec(0, a, 0, 0);
    // group 1: column 0 weights 1, ibuf all 1 -> 8
    add_vec(1, 0, 8, 0);
    add_vec(1, 1, 0, 0);
    add_vec(1, 2, 0, 0);
    add_vec(1, 7, 0, 0);
    // group 2: ibuf all 15 -> 120 saturates to 15, 120>>4 = 7
    add_vec(2, 2, 15, 7);
    add_vec(2, 0, 15, 7);
    add_vec(2, 1, 0, 0);
    // group 3 / 5: ibuf all 1 with columns 0 and 2 set
    add_vec(3, 0, 8, 0);
    add_vec(3, 2, 8, 0);
    add_vec(3, 1, 0, 0);
    for (int a = 0; a < N; a++) add_vec(4, a, 0, 0);
    add_vec(5, 0, 8, 0);
    add_vec(5, 1, 0, 0);
    add_vec(5, 2, 8, 0);

    rst = 1'b1; i_cim_we = 1'b0; i_cim_wr_addr = '0; i_cim_data = '0; i_cim_start = 1'b0;
    i_w_we = 1'b0; i_w_row = '0; i_w_col = '0; i_w_data = 1'b0; i_cim_rd_addr = '0;
    step();
    step();
    check("reset_busy", int'(busy0), 0);
    check("reset_done", int'(done0), 0);
    check("reset_data", int'(data0), 0);
    rst = 1'b0;

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wr_w(r, c, 1'b0);
    apply_group(0);

    for (int r = 0; r < N; r++) wr_w(r, 0, 1'b1);
    fill_ibuf(1);
    run_and_wait("mvm_basic");
    apply_group(1);

    fill_ibuf(15);
    for (int r = 0; r < N; r++) wr_w(r, 2, 1'b1);
    run_and_wait("mvm_sat");
    apply_group(2);

    // Timing: start at edge T, sample after each edge T+j
    fill_ibuf(1);
    busy_cnt = 0;
    i_cim_start = 1'b1;
    step();
    i_cim_start = 1'b0;
    for (int j = 0; j < 12; j++) begin
      check($sformatf("timing_busy_j%0d", j), int'(busy0), (j <= 8) ? 1 : 0);
      check($sformatf("timing_done_j%0d", j), int'(done0), (j == 8) ? 1 : 0);
      if (busy0) busy_cnt++;
      if (j == 2) i_cim_start = 1'b1;
      if (j == 3) begin
        i_cim_start = 1'b0;
        i_cim_we = 1'b1; i_cim_wr_addr = '0; i_cim_data = 4'd5;
      end
      if (j == 4) i_cim_we = 1'b0;
      step();
    end
    check("timing_busy_cycles", busy_cnt, 9);
    run_and_wait("mvm_after_busy_write");
    apply_group(3);

    // Reset abort while col=3
    i_cim_start = 1'b1;
    step();
    i_cim_start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", int'(busy0), 0);
    check("abort_done", int'(done0), 0);
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (done0) done_cnt++;
      step();
    end
    check("abort_no_done_pulse", done_cnt, 0);
    apply_group(4);
    fill_ibuf(1);
    run_and_wait("mvm_after_abort");
    apply_group(5);

    // Read-during-compute on column 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    fill_ibuf(1);
    i_cim_rd_addr = '0;
    i_cim_start = 1'b1;
    step();
    i_cim_start = 1'b0;
    check("live_read_j0", int'(data0), 0);
    step();
    check("live_read_j1_old", int'(data0), 0);
    step();
    check("live_read_j2_new", int'(data0), 8);
    check("live_read_j2_s4", int'(data4), 0);
    done_cnt = 0;
    for (int k = 0; k < 20 && done_cnt == 0; k++) begin
      if (done0) done_cnt++;
      step();
    end
    check("live_read_done_seen", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
